// File: rtl/enokida_sa_cache.sv
// Set-associative write-through data cache between the RI5CY LSU data port and data memory.
// One word per line, per-set round-robin replacement, no write-allocate, lockable saturating statistics.
module enokida_sa_cache #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 16,
   parameter int WAYS       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  proc_cache_data_req_i,
   input  logic [ADDR_WIDTH-1:0] proc_cache_data_addr_i,
   input  logic                  proc_cache_data_we_i,
   input  logic [3:0]            proc_cache_data_be_i,
   input  logic [DATA_WIDTH-1:0] proc_cache_data_wdata_i,
   output logic                  proc_cache_data_gnt_o,
   output logic                  proc_cache_data_rvalid_o,
   output logic [DATA_WIDTH-1:0] proc_cache_data_rdata_o,
   input  logic                  cache_mem_data_gnt_i,
   input  logic                  cache_mem_data_rvalid_i,
   input  logic [DATA_WIDTH-1:0] cache_mem_data_rdata_i,
   output logic                  cache_mem_data_req_o,
   output logic [ADDR_WIDTH-1:0] cache_mem_data_addr_o,
   output logic                  cache_mem_data_we_o,
   output logic [3:0]            cache_mem_data_be_o,
   output logic [DATA_WIDTH-1:0] cache_mem_data_wdata_o,
   input  logic                  flush_i,
   input  logic                  lock,
   output logic [31:0]           trans_count,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count,
   output logic [1:0]            state_dbg
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, HIT_RESP, MEM_REQ, MEM_WAIT} state_t;
   state_t state, state_next;

   logic                  valid_q [SETS][WAYS];
   logic [TAG_W-1:0]      tags_q  [SETS][WAYS];
   logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
   logic [WAY_W-1:0]      rr_q    [SETS];

   logic [IDX_W-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0] req_tag, fill_tag;
   logic             accept, hit, all_valid;
   logic [WAY_W-1:0] hit_way, victim, victim_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic             unused_addr_bits;

   assign req_idx  = proc_cache_data_addr_i[IDX_W+1:2];
   assign req_tag  = proc_cache_data_addr_i[ADDR_WIDTH-1:IDX_W+2];
   assign fill_idx = cache_mem_data_addr_o[IDX_W+1:2];
   assign fill_tag = cache_mem_data_addr_o[ADDR_WIDTH-1:IDX_W+2];
   assign unused_addr_bits = ^proc_cache_data_addr_i[1:0];

   assign accept                   = (state == IDLE) && proc_cache_data_req_i && !flush_i;
   assign proc_cache_data_gnt_o    = accept;
   assign proc_cache_data_rvalid_o = (state == HIT_RESP);
   assign proc_cache_data_rdata_o  = rdata_q;
   assign state_dbg                = state;

   // Parallel tag compare; victim is the lowest invalid way, else the set's round-robin pointer.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      all_valid = 1'b1;
      victim    = rr_q[req_idx];
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && (tags_q[req_idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[req_idx][w]) begin
            all_valid = 1'b0;
            victim    = WAY_W'(w);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (accept) state_next = (hit && !proc_cache_data_we_i) ? HIT_RESP : MEM_REQ;
         MEM_REQ:  if (cache_mem_data_gnt_i) state_next = MEM_WAIT;
         MEM_WAIT: if (cache_mem_data_rvalid_i) state_next = HIT_RESP;
         HIT_RESP: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q                <= '0;
         cache_mem_data_req_o   <= 1'b0;
         cache_mem_data_addr_o  <= '0;
         cache_mem_data_we_o    <= 1'b0;
         cache_mem_data_be_o    <= 4'h0;
         cache_mem_data_wdata_o <= '0;
         victim_q               <= '0;
         trans_count            <= '0;
         hit_count              <= '0;
         miss_count             <= '0;
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
         end
      end else begin
         if ((state == IDLE) && flush_i) begin
            for (int s = 0; s < SETS; s++)
               for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
         end
         if (accept) begin
            cache_mem_data_addr_o  <= {proc_cache_data_addr_i[ADDR_WIDTH-1:2], 2'b00};
            cache_mem_data_we_o    <= proc_cache_data_we_i;
            cache_mem_data_be_o    <= proc_cache_data_we_i ? proc_cache_data_be_i : 4'hF;
            cache_mem_data_wdata_o <= proc_cache_data_wdata_i;
            victim_q               <= victim;
            if (proc_cache_data_we_i || !hit) cache_mem_data_req_o <= 1'b1;
            if (!proc_cache_data_we_i && hit) rdata_q <= data_q[req_idx][hit_way];
            if (!proc_cache_data_we_i && !hit && all_valid)
               rr_q[req_idx] <= (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
            if (!lock) begin
               if (trans_count != 32'hFFFF_FFFF) trans_count <= trans_count + 1;
               if (hit && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 1;
               if (!hit && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 1;
            end
         end
         if ((state == MEM_REQ) && cache_mem_data_gnt_i) cache_mem_data_req_o <= 1'b0;
         if ((state == MEM_WAIT) && cache_mem_data_rvalid_i) begin
            rdata_q <= cache_mem_data_we_o ? '0 : cache_mem_data_rdata_i;
            if (!cache_mem_data_we_o) valid_q[fill_idx][victim_q] <= 1'b1;
         end
      end
   end

   // Line storage needs no reset: a line is only ever read while its valid bit is set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept && proc_cache_data_we_i && hit) begin
            for (int b = 0; b < 4; b++)
               if (proc_cache_data_be_i[b])
                  data_q[req_idx][hit_way][8*b +: 8] <= proc_cache_data_wdata_i[8*b +: 8];
         end
         if ((state == MEM_WAIT) && cache_mem_data_rvalid_i && !cache_mem_data_we_o) begin
            tags_q[fill_idx][victim_q] <= fill_tag;
            data_q[fill_idx][victim_q] <= cache_mem_data_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_enokida_sa_cache.sv
// Directed bench for enokida_sa_cache: hits, misses, replacement, write-through, flush,
// counter lock/saturation and reset in the middle of a memory transaction.
module tb_enokida_sa_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we, gnt, rvalid;
   logic [15:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata, rdata;
   logic        mem_gnt, mem_rvalid, mem_req, mem_we;
   logic [31:0] mem_rdata, mem_wdata;
   logic [15:0] mem_addr;
   logic [3:0]  mem_be;
   logic        flush, lock;
   logic [31:0] trans_count, hit_count, miss_count;
   logic [1:0]  state_dbg;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   enokida_sa_cache #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .SETS(16), .WAYS(2)) dut (
      .clk(clk), .rst(rst),
      .proc_cache_data_req_i(req), .proc_cache_data_addr_i(addr), .proc_cache_data_we_i(we),
      .proc_cache_data_be_i(be), .proc_cache_data_wdata_i(wdata),
      .proc_cache_data_gnt_o(gnt), .proc_cache_data_rvalid_o(rvalid), .proc_cache_data_rdata_o(rdata),
      .cache_mem_data_gnt_i(mem_gnt), .cache_mem_data_rvalid_i(mem_rvalid), .cache_mem_data_rdata_i(mem_rdata),
      .cache_mem_data_req_o(mem_req), .cache_mem_data_addr_o(mem_addr), .cache_mem_data_we_o(mem_we),
      .cache_mem_data_be_o(mem_be), .cache_mem_data_wdata_o(mem_wdata),
      .flush_i(flush), .lock(lock),
      .trans_count(trans_count), .hit_count(hit_count), .miss_count(miss_count),
      .state_dbg(state_dbg)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_counts(input string tag, input logic [31:0] t, input logic [31:0] h,
                               input logic [31:0] m);
      check_val({tag, "_trans"}, trans_count, t);
      check_val({tag, "_hit"}, hit_count, h);
      check_val({tag, "_miss"}, miss_count, m);
   endtask

   // One processor access with a zero-wait memory; latency counts cycles from gnt to rvalid.
   task automatic do_access(input string tag, input logic [15:0] a, input logic w, input logic [3:0] b,
                            input logic [31:0] wd, input logic [31:0] mdata, input logic exp_mem,
                            input logic [31:0] exp_rd, input int exp_lat);
      logic        got, granted, responded, seen_we;
      logic [15:0] seen_addr;
      logic [3:0]  seen_be;
      logic [31:0] seen_wdata, got_rd;
      int          lat;
      got = 0; granted = 0; responded = 0; lat = 0; got_rd = '0;
      seen_we = 0; seen_addr = '0; seen_be = '0; seen_wdata = '0;
      @(negedge clk);
      req = 1; addr = a; we = w; be = b; wdata = wd;
      #1 check_val({tag, "_gnt"}, 32'(gnt), 32'd1);
      @(negedge clk);
      req = 0;
      for (int n = 1; n <= 20; n++) begin
         mem_gnt = 0; mem_rvalid = 0;
         if (rvalid) begin
            got = 1; lat = n; got_rd = rdata;
            break;
         end
         if (mem_req && !granted) begin
            granted = 1; mem_gnt = 1;
            seen_addr = mem_addr; seen_we = mem_we; seen_be = mem_be; seen_wdata = mem_wdata;
         end else if (granted && !responded) begin
            responded = 1; mem_rvalid = 1; mem_rdata = mdata;
         end
         @(negedge clk);
      end
      mem_gnt = 0; mem_rvalid = 0;
      check_val({tag, "_rvalid"}, 32'(got), 32'd1);
      check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_val({tag, "_rdata"}, got_rd, exp_rd);
      check_val({tag, "_mem_req"}, 32'(granted), 32'(exp_mem));
      if (exp_mem) begin
         check_val({tag, "_mem_addr"}, 32'(seen_addr), 32'({a[15:2], 2'b00}));
         check_val({tag, "_mem_we"}, 32'(seen_we), 32'(w));
         check_val({tag, "_mem_be"}, 32'(seen_be), w ? 32'(b) : 32'hF);
         if (w) check_val({tag, "_mem_wdata"}, seen_wdata, wd);
      end
      @(negedge clk);
      check_val({tag, "_rvalid_pulse"}, 32'(rvalid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int rv_seen;
      rst = 1; req = 0; addr = '0; we = 0; be = '0; wdata = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; flush = 0; lock = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      check_counts("reset", 32'd0, 32'd0, 32'd0);
      check_val("reset_rvalid", 32'(rvalid), 32'd0);
      check_val("reset_rdata", rdata, 32'd0);
      check_val("reset_mem_req", 32'(mem_req), 32'd0);
      check_val("reset_mem_addr", 32'(mem_addr), 32'd0);

      do_access("rd_miss", 16'h0040, 0, 4'h0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 3);
      check_counts("after_miss", 32'd1, 32'd0, 32'd1);
      do_access("rd_hit", 16'h0040, 0, 4'h0, 0, 32'h0, 0, 32'hDEADBEEF, 1);
      check_counts("after_hit", 32'd2, 32'd1, 32'd1);
      do_access("wr_hit", 16'h0040, 1, 4'b0011, 32'h12345678, 32'hAAAAAAAA, 1, 32'h0, 3);
      do_access("rd_merged", 16'h0040, 0, 4'h0, 0, 32'h0, 0, 32'hDEAD5678, 1);
      check_counts("after_wr_hit", 32'd4, 32'd3, 32'd1);

      do_access("conf_440", 16'h0440, 0, 4'h0, 0, 32'h44404440, 1, 32'h44404440, 3);
      do_access("conf_840", 16'h0840, 0, 4'h0, 0, 32'h88408840, 1, 32'h88408840, 3);
      do_access("conf_040", 16'h0040, 0, 4'h0, 0, 32'hCAFE0040, 1, 32'hCAFE0040, 3);
      check_counts("after_conflict", 32'd7, 32'd3, 32'd4);
      do_access("conf_840_hit", 16'h0840, 0, 4'h0, 0, 32'h0, 0, 32'h88408840, 1);

      do_access("wr_miss", 16'h0100, 1, 4'hF, 32'h0BADF00D, 32'h55555555, 1, 32'h0, 3);
      do_access("rd_no_alloc", 16'h0100, 0, 4'h0, 0, 32'h01000100, 1, 32'h01000100, 3);
      do_access("rd_040_kept", 16'h0040, 0, 4'h0, 0, 32'h0, 0, 32'hCAFE0040, 1);
      check_counts("before_flush", 32'd11, 32'd5, 32'd6);

      @(negedge clk);
      req = 1; addr = 16'h0040; we = 0; flush = 1;
      #1 check_val("flush_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
      req = 0; flush = 0;
      check_counts("flush_no_accept", 32'd11, 32'd5, 32'd6);
      do_access("rd_after_flush", 16'h0040, 0, 4'h0, 0, 32'hF00D0040, 1, 32'hF00D0040, 3);
      check_counts("after_flush", 32'd12, 32'd5, 32'd7);

      lock = 1;
      for (int i = 0; i < 3; i++)
         do_access("locked", 16'h0040, 0, 4'h0, 0, 32'h0, 0, 32'hF00D0040, 1);
      check_counts("locked", 32'd12, 32'd5, 32'd7);
      lock = 0;

      @(negedge clk);
      force dut.trans_count = 32'hFFFF_FFFF;
      #1 release dut.trans_count;
      do_access("saturate", 16'h0040, 0, 4'h0, 0, 32'h0, 0, 32'hF00D0040, 1);
      check_counts("saturate", 32'hFFFF_FFFF, 32'd6, 32'd7);

      // Abandon a read miss during MEM_WAIT, then deliver a late memory response.
      rv_seen = 0;
      @(negedge clk);
      req = 1; addr = 16'h0200; we = 0;
      @(negedge clk);
      req = 0;
      check_val("rst_mid_req", 32'(mem_req), 32'd1);
      mem_gnt = 1;
      @(negedge clk);
      mem_gnt = 0; rst = 1;
      @(negedge clk);
      rst = 0; mem_rvalid = 1; mem_rdata = 32'h99990200;
      if (rvalid) rv_seen++;
      @(negedge clk);
      mem_rvalid = 0;
      for (int i = 0; i < 4; i++) begin
         if (rvalid) rv_seen++;
         @(negedge clk);
      end
      check_val("rst_mid_no_rvalid", 32'(rv_seen), 32'd0);
      check_counts("rst_mid", 32'd0, 32'd0, 32'd0);
      check_val("rst_mid_mem_req", 32'(mem_req), 32'd0);
      do_access("rst_mid_no_fill", 16'h0200, 0, 4'h0, 0, 32'h22220200, 1, 32'h22220200, 3);
      check_counts("rst_mid_after", 32'd1, 32'd0, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/enokida_sa_cache.md
# enokida_sa_cache

Parametrised set-associative successor to the direct-mapped data cache. Sits between the RI5CY LSU data port and data memory, speaking the RI5CY req/gnt/rvalid protocol on both sides. Configurable set count and associativity, with per-set round-robin replacement, write-through/no-write-allocate stores, a bulk flush, and lockable saturating statistics counters. One cache line is one DATA_WIDTH word.

## Interface
- ADDR_WIDTH, 16, byte address width on both ports
- DATA_WIDTH, 32, data width; only 32 is supported
- SETS, 16, number of sets; power of two, ≥2
- WAYS, 2, associativity; power of two, 1..8

- clk  in  1  sole clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- proc_cache_data_req_i / _addr_i / _we_i / _be_i / _wdata_i  in  1/ADDR_WIDTH/1/4/32  processor request
- proc_cache_data_gnt_o  out  1  request accepted
- proc_cache_data_rvalid_o  out  1  response valid, single-cycle pulse
- proc_cache_data_rdata_o  out  32  read data, valid with rvalid
- cache_mem_data_gnt_i / _rvalid_i / _rdata_i  in  1/1/32  memory response
- cache_mem_data_req_o / _addr_o / _we_o / _be_o / _wdata_o  out  1/ADDR_WIDTH/1/4/32  memory request
- flush_i  in  1  invalidate all lines
- lock  in  1  freezes all three counters while high
- trans_count, hit_count, miss_count  out  32 each  statistics

## Operation
- Address split: offset = addr[1:0] (ignored), index = addr[log2(SETS)+1:2], tag = remaining upper bits. Memory accesses are word-aligned.
- States:
  - IDLE
  - HIT_RESP
  - MEM_REQ
  - MEM_WAIT
- IDLE:
  - gnt_o = req_i & ~flush_i (combinational).
  - flush_i clears every valid bit in one cycle and takes priority over req.
  - On accept, register addr/we/be/wdata and perform the tag lookup on all ways in parallel.
- Read hit: go to HIT_RESP and return the way's data.
- Read miss: go to MEM_REQ with we=0, be=4'hF.
  - Victim is the lowest-numbered invalid way; if all ways are valid, the set's round-robin pointer picks the victim.
  - The pointer advances modulo WAYS only when it supplied the victim.
- Write, hit or miss: go to MEM_REQ and write-through with the registered be/wdata.
  - On a hit, the enabled bytes in the hit way are updated on accept.
  - On a miss, no line is allocated.
- MEM_REQ: req_o held high with stable addr/we/be/wdata until gnt_i, then go to MEM_WAIT with req_o low the next cycle.
- MEM_WAIT: on mem rvalid_i, go to HIT_RESP.
  - Read miss: fill the victim (tag, data, valid) and forward rdata.
  - Write: rdata_o = 0.
- HIT_RESP: rvalid_o = 1 for one cycle, then back to IDLE.
- Counters, at accept and only while lock = 0:
  - trans_count +1 on every request.
  - hit_count +1 on a tag hit (read or write).
  - miss_count +1 otherwise.
  - Each counter saturates at 32'hFFFF_FFFF.
- mem rvalid_i outside MEM_WAIT is ignored.

## Timing
- Reset (cycle after rst sampled high):
  - State IDLE; all valid bits, round-robin pointers and counters 0.
  - rvalid_o, rdata_o, req_o, addr_o, we_o, be_o, wdata_o = 0.
- Read hit: gnt at T, rvalid + data at T+1. Back-to-back hits are accepted every 2 cycles.
- Miss / write:
  - gnt at T, req_o from T+1 until the cycle of mem gnt.
  - Mem rvalid at cycle M gives proc rvalid at M+1.
  - Zero-wait memory (gnt at T+1, rvalid at T+2) gives proc rvalid at T+3.
- gnt_o is never high outside IDLE.
- Reset mid-transaction abandons it: no proc rvalid is issued, and a late mem rvalid is ignored.
- flush_i while not in IDLE is ignored; it must be held until IDLE to take effect.
- Simultaneous lock and accept: counters are not updated.

## Test plan
- Read miss then hit, SETS=16, WAYS=2, addr 0x0040, mem returns 0xDEADBEEF:
  - 1st access: mem req, proc rvalid at M+1 with 0xDEADBEEF, miss_count=1.
  - 2nd access: rvalid at T+1, no mem req, hit_count=1, trans_count=2.
- Conflict/replacement: read 0x0040, 0x0440, 0x0840 (same set, distinct tags), then 0x0040.
  - 0x0840 evicts way 0, so the final 0x0040 misses; miss_count=4.
- Write hit, be=4'b0011, wdata=0x1234_5678 to a line holding 0xDEADBEEF:
  - Mem write issued with be=4'b0011.
  - Subsequent read hits and returns 0xDEAD5678.
- Write miss to 0x0100: mem write issued; a following read of 0x0100 misses (no allocate).
- Flush:
  - Fill 0x0040, assert flush_i for one IDLE cycle with req high; gnt is low that cycle.
  - Next read of 0x0040 misses.
- Counter behaviour:
  - With lock=1, 3 accepted requests leave all counters unchanged.
  - Force trans_count to 32'hFFFF_FFFF, then one more request: value stays 32'hFFFF_FFFF.
- Reset during MEM_WAIT: no proc rvalid; a later mem rvalid produces no response and no fill.
